fridge_cooling_scheduler: RTL

Shares the single compressor between the fridge and freezer compartments. Takes the setpoints held by the fridge temperature registers, plus measured compartment temperatures. Drives compressor enable, routing valve and defrost heater. Adds hysteresis, minimum on/off times for compressor protection, round-robin arbitration and a periodic defrost cycle. Sits beside the fridge top level and consumes its fgt/frt outputs.

---
 rtl/fridge_cooling_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fridge_cooling_scheduler.sv
// Compressor scheduler shared by the fridge and freezer compartments: hysteretic demand,
// minimum on/off protection, round-robin arbitration and a periodic defrost cycle.
module fridge_cooling_scheduler #(
    parameter int TW            = 5,
    parameter int HYST          = 2,
    parameter int MIN_ON        = 8,
    parameter int MIN_OFF       = 6,
    parameter int DEFROST_EVERY = 4,
    parameter int DEFROST_LEN   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i,
    input  logic [TW-1:0] fgt_set,
    input  logic [TW-1:0] frt_set,
    input  logic [TW-1:0] fg_temp,
    input  logic [TW-1:0] fr_temp,
    input  logic          door_open,
    output logic          comp_on,
    output logic          valve_fr,
    output logic          defrost_on,
    output logic [2:0]    state,
    output logic [2:0]    run_cnt
);

    localparam int T_A     = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int TMAX    = (T_A > DEFROST_LEN) ? T_A : DEFROST_LEN;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam logic [TIMER_W-1:0] TIMER_SAT = {TIMER_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COOL_FG = 3'd1,
        COOL_FR = 3'd2,
        HOLD    = 3'd3,
        DEFROST = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [2:0]           run_cnt_reg, run_cnt_next;
    logic                 rr_reg, rr_next;
    logic [1:0]           dem_reg, dem_next;
    logic                 comp_on_reg, valve_fr_reg, defrost_on_reg;
    logic                 dem_fg, dem_fr, served, other, min_on_done;

    // Index 0 is the fridge, index 1 the freezer.
    logic [TW-1:0] temp_arr [2];
    logic [TW-1:0] set_arr  [2];
    assign temp_arr[0] = fg_temp;
    assign temp_arr[1] = fr_temp;
    assign set_arr[0]  = fgt_set;
    assign set_arr[1]  = frt_set;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dem
            logic [TW:0] temp_ext, set_ext, on_thresh;
            assign temp_ext  = {1'b0, temp_arr[gi]};
            assign set_ext   = {1'b0, set_arr[gi]};
            // One extra bit keeps setpoint+HYST from wrapping at the top of the range.
            assign on_thresh = set_ext + (TW + 1)'(HYST);
            assign dem_next[gi] = (temp_ext > on_thresh) ? 1'b1 :
                                  (temp_ext <= set_ext)  ? 1'b0 : dem_reg[gi];
        end
    endgenerate

    assign dem_fg      = dem_reg[0];
    assign dem_fr      = dem_reg[1];
    assign min_on_done = (timer_reg >= TIMER_W'(MIN_ON - 1));

    always_comb begin
        state_next   = state_reg;
        run_cnt_next = run_cnt_reg;
        rr_next      = rr_reg;
        served       = 1'b0;
        other        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i && !door_open && (dem_fg || dem_fr)) begin
                    if (dem_fg && dem_fr) begin
                        state_next = rr_reg ? COOL_FR : COOL_FG;
                        rr_next    = ~rr_reg;
                    end else if (dem_fr) begin
                        state_next = COOL_FR;
                    end else begin
                        state_next = COOL_FG;
                    end
                end
            end
            COOL_FG, COOL_FR: begin
                served = (state_reg == COOL_FR) ? dem_fr : dem_fg;
                other  = (state_reg == COOL_FR) ? dem_fg : dem_fr;
                if (min_on_done && !served) begin
                    if (other) begin
                        // Hand the running compressor to the other compartment.
                        state_next = (state_reg == COOL_FR) ? COOL_FG : COOL_FR;
                    end else if (run_cnt_reg >= 3'(DEFROST_EVERY - 1)) begin
                        state_next   = DEFROST;
                        run_cnt_next = 3'd0;
                    end else begin
                        state_next   = HOLD;
                        run_cnt_next = run_cnt_reg + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (timer_reg == TIMER_W'(MIN_OFF - 1))
                    state_next = IDLE;
            end
            DEFROST: begin
                if (timer_reg == TIMER_W'(DEFROST_LEN - 1))
                    state_next = HOLD;
            end
            default: state_next = HOLD;
        endcase
        if (!i) begin
            state_next   = HOLD;
            run_cnt_next = run_cnt_reg;
            rr_next      = rr_reg;
        end
    end

    // Timer restarts on every state change and is pinned at 0 while power is off.
    assign timer_next = ((state_next != state_reg) || !i) ? '0 :
                        (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HOLD;
            timer_reg      <= '0;
            run_cnt_reg    <= 3'd0;
            rr_reg         <= 1'b1;
            dem_reg        <= 2'b00;
            comp_on_reg    <= 1'b0;
            valve_fr_reg   <= 1'b0;
            defrost_on_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            run_cnt_reg    <= run_cnt_next;
            rr_reg         <= rr_next;
            dem_reg        <= dem_next;
            comp_on_reg    <= (state_next == COOL_FG) || (state_next == COOL_FR);
            valve_fr_reg   <= (state_next == COOL_FR);
            defrost_on_reg <= (state_next == DEFROST);
        end
    end

    assign comp_on    = comp_on_reg;
    assign valve_fr   = valve_fr_reg;
    assign defrost_on = defrost_on_reg;
    assign state      = state_reg;
    assign run_cnt    = run_cnt_reg;

endmodule
